// File: rtl/magnitude_framer.sv
// magnitude_framer: groups a strobed magnitude stream into frames of
// 2^FRAME_LEN_LOG2 samples and reports the truncated mean and the peak of
// each completed frame, with a one-cycle strobe and a wrapping frame index.
// The peak tracker is only built when MAGNITUDE_FRAMER_PEAK_EN is defined;
// otherwise peak_out is tied to zero.
module magnitude_framer #(
    parameter int DATA_IN_BITS     = 17,
    parameter int FRAME_LEN_LOG2   = 8,
    parameter int FRAME_COUNT_BITS = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        data_in_ready,
    input  logic [DATA_IN_BITS-1:0]     data_in,
    input  logic                        frame_flush,
    output logic [DATA_IN_BITS-1:0]     avg_out,
    output logic [DATA_IN_BITS-1:0]     peak_out,
    output logic [FRAME_COUNT_BITS-1:0] frame_count,
    output logic                        frame_out_ready
);

    localparam int ACC_W = DATA_IN_BITS + FRAME_LEN_LOG2;

    localparam logic [FRAME_LEN_LOG2-1:0]   CNT_LAST  = {FRAME_LEN_LOG2{1'b1}};
    localparam logic [FRAME_LEN_LOG2-1:0]   CNT_ZERO  = {FRAME_LEN_LOG2{1'b0}};
    localparam logic [FRAME_LEN_LOG2-1:0]   CNT_ONE   = {{(FRAME_LEN_LOG2-1){1'b0}}, 1'b1};
    localparam logic [ACC_W-1:0]            ACC_ZERO  = {ACC_W{1'b0}};
    localparam logic [DATA_IN_BITS-1:0]     DATA_ZERO = {DATA_IN_BITS{1'b0}};
    localparam logic [FRAME_COUNT_BITS-1:0] FC_ZERO   = {FRAME_COUNT_BITS{1'b0}};
    localparam logic [FRAME_COUNT_BITS-1:0] FC_ONE    = {{(FRAME_COUNT_BITS-1){1'b0}}, 1'b1};

    // Unsigned maximum of two samples.
    function automatic logic [DATA_IN_BITS-1:0] max_u(
        input logic [DATA_IN_BITS-1:0] a,
        input logic [DATA_IN_BITS-1:0] b
    );
        if (a >= b) begin
            max_u = a;
        end else begin
            max_u = b;
        end
    endfunction

    // Sample count doubles as the frame state: zero means EMPTY.
    logic [FRAME_LEN_LOG2-1:0]   sample_cnt_r, sample_cnt_nxt_s;
    logic [ACC_W-1:0]            acc_r, acc_nxt_s;
    logic [ACC_W-1:0]            sum_s;
    logic [ACC_W-1:0]            avg_wide_s;
    logic [ACC_W-1:0]            data_ext_s;
    logic [DATA_IN_BITS-1:0]     avg_r, avg_nxt_s;
    logic [FRAME_COUNT_BITS-1:0] frame_count_r, frame_count_nxt_s;
    logic                        strobe_r, strobe_nxt_s;
    logic                        last_s;

    // A frame completes only on its last sample when no flush overrides it.
    assign last_s     = data_in_ready && !frame_flush && (sample_cnt_r == CNT_LAST);
    assign data_ext_s = {{FRAME_LEN_LOG2{1'b0}}, data_in};
    assign sum_s      = acc_r + data_ext_s;
    assign avg_wide_s = sum_s >> FRAME_LEN_LOG2;

    // Next-state for accumulator, sample counter and the mean/count outputs.
    always_comb begin
        acc_nxt_s         = acc_r;
        sample_cnt_nxt_s  = sample_cnt_r;
        avg_nxt_s         = avg_r;
        frame_count_nxt_s = frame_count_r;
        strobe_nxt_s      = 1'b0;
        if (frame_flush) begin
            // Flush drops the partial frame; a coincident sample starts the next one.
            if (data_in_ready) begin
                acc_nxt_s        = data_ext_s;
                sample_cnt_nxt_s = CNT_ONE;
            end else begin
                acc_nxt_s        = ACC_ZERO;
                sample_cnt_nxt_s = CNT_ZERO;
            end
        end else if (last_s) begin
            avg_nxt_s         = avg_wide_s[DATA_IN_BITS-1:0];
            frame_count_nxt_s = frame_count_r + FC_ONE;
            strobe_nxt_s      = 1'b1;
            acc_nxt_s         = ACC_ZERO;
            sample_cnt_nxt_s  = CNT_ZERO;
        end else if (data_in_ready) begin
            acc_nxt_s        = sum_s;
            sample_cnt_nxt_s = sample_cnt_r + CNT_ONE;
        end else begin
            acc_nxt_s        = acc_r;
            sample_cnt_nxt_s = sample_cnt_r;
        end
    end

    // State and output registers for the mean path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r         <= ACC_ZERO;
            sample_cnt_r  <= CNT_ZERO;
            avg_r         <= DATA_ZERO;
            frame_count_r <= FC_ZERO;
            strobe_r      <= 1'b0;
        end else begin
            acc_r         <= acc_nxt_s;
            sample_cnt_r  <= sample_cnt_nxt_s;
            avg_r         <= avg_nxt_s;
            frame_count_r <= frame_count_nxt_s;
            strobe_r      <= strobe_nxt_s;
        end
    end

    assign avg_out         = avg_r;
    assign frame_count     = frame_count_r;
    assign frame_out_ready = strobe_r;

`ifdef MAGNITUDE_FRAMER_PEAK_EN
    logic [DATA_IN_BITS-1:0] peak_run_r, peak_run_nxt_s;
    logic [DATA_IN_BITS-1:0] peak_out_r, peak_out_nxt_s;
    logic [DATA_IN_BITS-1:0] peak_cand_s;

    // Running peak follows the same flush/last rules as the accumulator.
    always_comb begin
        peak_cand_s    = max_u(peak_run_r, data_in);
        peak_run_nxt_s = peak_run_r;
        peak_out_nxt_s = peak_out_r;
        if (frame_flush) begin
            if (data_in_ready) begin
                peak_run_nxt_s = data_in;
            end else begin
                peak_run_nxt_s = DATA_ZERO;
            end
        end else if (last_s) begin
            peak_out_nxt_s = peak_cand_s;
            peak_run_nxt_s = DATA_ZERO;
        end else if (data_in_ready) begin
            peak_run_nxt_s = peak_cand_s;
        end else begin
            peak_run_nxt_s = peak_run_r;
        end
    end

    // Peak state and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            peak_run_r <= DATA_ZERO;
            peak_out_r <= DATA_ZERO;
        end else begin
            peak_run_r <= peak_run_nxt_s;
            peak_out_r <= peak_out_nxt_s;
        end
    end

    assign peak_out = peak_out_r;
`else
    assign peak_out = DATA_ZERO;
`endif

endmodule

// File: tb/tb_magnitude_framer.sv
// Self-checking bench for magnitude_framer (frame length 4, 17-bit samples,
// 2-bit frame counter). A queue-based frame model predicts every output on
// every cycle; directed scenarios add explicit expected constants.
module tb_magnitude_framer;

    localparam int DW   = 17;
    localparam int LG   = 2;
    localparam int FCB  = 2;
    localparam int FLEN = 4;
`ifdef MAGNITUDE_FRAMER_PEAK_EN
    localparam bit PEAK_BUILT = 1'b1;
`else
    localparam bit PEAK_BUILT = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           data_in_ready = 1'b0;
    logic [DW-1:0]  data_in = '0;
    logic           frame_flush = 1'b0;
    logic [DW-1:0]  avg_out;
    logic [DW-1:0]  peak_out;
    logic [FCB-1:0] frame_count;
    logic           frame_out_ready;

    magnitude_framer #(
        .DATA_IN_BITS(DW),
        .FRAME_LEN_LOG2(LG),
        .FRAME_COUNT_BITS(FCB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_in_ready(data_in_ready),
        .data_in(data_in),
        .frame_flush(frame_flush),
        .avg_out(avg_out),
        .peak_out(peak_out),
        .frame_count(frame_count),
        .frame_out_ready(frame_out_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int strobes = 0;

    // Reference model state
    int unsigned frame_q[$];
    int unsigned exp_avg = 0;
    int unsigned exp_peak = 0;
    int unsigned exp_fc = 0;
    int unsigned exp_strobe = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        chk("strobe", {31'd0, frame_out_ready}, exp_strobe);
        chk("avg", {15'd0, avg_out}, exp_avg);
        chk("peak", {15'd0, peak_out}, PEAK_BUILT ? exp_peak : 32'd0);
        chk("frame_count", {30'd0, frame_count}, exp_fc);
    endtask

    // Frame rules in plain terms: flush forgets the partial frame, a valid
    // sample joins the frame, and a full frame yields sum/len, max and a count.
    task automatic model_update(input bit rdy, input int unsigned d, input bit fl);
        longint unsigned s;
        int unsigned m;
        exp_strobe = 0;
        if (fl) frame_q.delete();
        if (rdy) begin
            frame_q.push_back(d);
            if (frame_q.size() == FLEN) begin
                s = 0;
                m = 0;
                foreach (frame_q[i]) begin
                    s += frame_q[i];
                    if (frame_q[i] > m) m = frame_q[i];
                end
                exp_avg    = int'(s / FLEN);
                exp_peak   = m;
                exp_fc     = (exp_fc + 1) % (1 << FCB);
                exp_strobe = 1;
                strobes++;
                frame_q.delete();
            end
        end
    endtask

    task automatic step(input bit rdy, input int unsigned d, input bit fl);
        data_in_ready = rdy;
        data_in       = d[DW-1:0];
        frame_flush   = fl;
        @(posedge clk);
        #1;
        model_update(rdy, d, fl);
        check_all();
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b0;
        #1;
        frame_q.delete();
        exp_avg = 0; exp_peak = 0; exp_fc = 0; exp_strobe = 0;
        check_all();
        for (int i = 0; i < ncyc; i++) begin
            data_in_ready = 1'($urandom_range(0, 1));
            data_in       = DW'($urandom_range(0, 131071));
            frame_flush   = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check_all();
        end
        @(negedge clk);
        rst           = 1'b1;
        data_in_ready = 1'b0;
        frame_flush   = 1'b0;
        data_in       = '0;
    endtask

    int s0;
    int unsigned fc_seq[5] = '{1, 2, 3, 0, 1};

    initial begin
        // Reset with random inputs
        do_reset(3);

        // Basic frame
        step(1, 10, 0); step(1, 20, 0); step(1, 30, 0); step(1, 40, 0);
        chk("basic_strobe", {31'd0, frame_out_ready}, 32'd1);
        chk("basic_avg", {15'd0, avg_out}, 32'd25);
        chk("basic_peak", {15'd0, peak_out}, PEAK_BUILT ? 32'd40 : 32'd0);
        chk("basic_fc", {30'd0, frame_count}, 32'd1);
        step(0, 0, 0);

        // Gapped frame A then back-to-back max frame B
        do_reset(1);
        s0 = strobes;
        step(1, 1, 0); step(0, 99, 0); step(1, 2, 0); step(0, 0, 0);
        step(1, 3, 0); step(0, 7, 0); step(0, 0, 0); step(1, 5, 0);
        chk("gapA_avg", {15'd0, avg_out}, 32'd2);
        chk("gapA_peak", {15'd0, peak_out}, PEAK_BUILT ? 32'd5 : 32'd0);
        for (int i = 0; i < 4; i++) step(1, 131071, 0);
        chk("maxB_avg", {15'd0, avg_out}, 32'd131071);
        chk("maxB_peak", {15'd0, peak_out}, PEAK_BUILT ? 32'd131071 : 32'd0);
        chk("gap_fc", {30'd0, frame_count}, 32'd2);
        step(0, 0, 0);
        chk("gap_strobes", strobes - s0, 32'd2);

        // Flush with coincident sample
        do_reset(1);
        s0 = strobes;
        step(1, 100, 0); step(1, 200, 0); step(1, 7, 1);
        step(1, 8, 0); step(1, 9, 0); step(1, 10, 0);
        chk("flush_avg", {15'd0, avg_out}, 32'd8);
        chk("flush_peak", {15'd0, peak_out}, PEAK_BUILT ? 32'd10 : 32'd0);
        step(0, 0, 0);
        chk("flush_strobes", strobes - s0, 32'd1);

        // Flush coincident with last sample, and flush while empty
        step(1, 4, 0); step(1, 4, 0); step(1, 4, 0); step(1, 4, 1);
        step(0, 0, 1); step(1, 4, 0); step(1, 4, 0); step(1, 4, 0);
        step(1, 0, 1); step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);

        // Reset mid-frame
        step(1, 50, 0); step(1, 60, 0);
        do_reset(1);
        step(1, 1, 0); step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
        chk("midrst_avg", {15'd0, avg_out}, 32'd1);
        chk("midrst_fc", {30'd0, frame_count}, 32'd1);

        // Frame counter wrap over five frames
        do_reset(1);
        for (int f = 0; f < 5; f++) begin
            for (int k = 0; k < FLEN; k++) step(1, $urandom_range(0, 131071), 0);
            chk("wrap_fc", {30'd0, frame_count}, fc_seq[f]);
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0) ? 131071 : $urandom_range(0, 131071),
                 ($urandom_range(0, 15) == 0));
        end
        step(0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
